i2c_target_regs: RTL and testbench

- I2C target (responder) for the bus whose initiator side is driven by the Avalon bit-bang SDA/SCL PIOs.
- Decodes START/STOP, matches a 7-bit device address, ACKs, and maps I2C transfers onto a byte-wide local register port.
- Register pointer auto-increments, giving EEPROM-style addressing: write pointer, then read or write sequential bytes.
- Sits between the open-drain pads and a local register file. All logic runs in the clk domain with oversampled SCL/SDA.

---
 rtl/i2c_target_regs.sv | 195 +++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target that maps bus transfers onto a byte-wide register port.
// The register pointer auto-increments, giving EEPROM-style sequential access.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, WR_BYTE, ACK_W, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  state_t     state;
  logic       scl_meta, scl_sync, scl_hist;
  logic       sda_meta, sda_sync, sda_hist;
  logic [7:0] shift;
  logic [3:0] bit_cnt;
  logic       rw;
  logic       first_byte;

  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_cond, stop_cond;
  logic [7:0] rx_byte;

  // Synchronizers reset to the idle-high bus level so reset release makes no edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_hist <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_meta <= scl_in;
      scl_sync <= scl_meta;
      scl_hist <= scl_sync;
      sda_meta <= sda_in;
      sda_sync <= sda_meta;
      sda_hist <= sda_sync;
    end
  end

  assign scl_rise   = scl_sync & ~scl_hist;
  assign scl_fall   = ~scl_sync & scl_hist;
  assign sda_rise   = sda_sync & ~sda_hist;
  assign sda_fall   = ~sda_sync & sda_hist;
  assign start_cond = sda_fall & scl_sync;
  assign stop_cond  = sda_rise & scl_sync;
  assign rx_byte    = {shift[6:0], sda_sync};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sda_oe     <= 1'b0;
      reg_addr   <= 8'h00;
      reg_wdata  <= 8'h00;
      reg_we     <= 1'b0;
      busy       <= 1'b0;
      shift      <= 8'h00;
      bit_cnt    <= 4'd0;
      rw         <= 1'b0;
      first_byte <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      // The pointer steps on the clk after each write strobe.
      if (reg_we)
        reg_addr <= reg_addr + 8'd1;

      if (start_cond) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop_cond) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: ;

          ADDR: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (shift[6:0] == DEV_ADDR) begin
                  state      <= ACK_A;
                  rw         <= sda_sync;
                  first_byte <= 1'b1;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end
          end

          // bit_cnt 8: waiting to start the ACK; 9: ACK on the bus.
          ACK_A: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b1;
                busy    <= 1'b1;
                bit_cnt <= 4'd9;
              end else begin
                bit_cnt <= 4'd0;
                if (rw) begin
                  shift  <= reg_rdata;
                  sda_oe <= ~reg_rdata[7];
                  state  <= RD_BYTE;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= WR_BYTE;
                end
              end
            end
          end

          WR_BYTE: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                state <= ACK_W;
                if (first_byte) begin
                  reg_addr   <= rx_byte;
                  first_byte <= 1'b0;
                end else begin
                  reg_wdata <= rx_byte;
                  reg_we    <= 1'b1;
                end
              end
            end
          end

          ACK_W: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b1;
                bit_cnt <= 4'd9;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= WR_BYTE;
              end
            end
          end

          RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= RD_ACK;
              end else begin
                shift  <= {shift[6:0], shift[7]};
                sda_oe <= ~shift[6];
              end
            end
          end

          RD_ACK: begin
            if (scl_rise && bit_cnt == 4'd8) begin
              reg_addr <= reg_addr + 8'd1;
              bit_cnt  <= 4'd9;
              if (sda_sync)
                state <= WAIT_STOP;
            end else if (scl_fall && bit_cnt == 4'd9) begin
              shift   <= reg_rdata;
              sda_oe  <= ~reg_rdata[7];
              bit_cnt <= 4'd0;
              state   <= RD_BYTE;
            end
          end

          WAIT_STOP: sda_oe <= 1'b0;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench acting as the I2C initiator, with a transaction-level model of the
// target's pointer, ACK decisions and expected register writes.
module tb_i2c_target_regs;
  localparam logic [6:0] DEV = 7'h50;
  localparam time Q = 200ns;

  typedef enum {P_ADDR, P_PTR, P_DATA, P_READ, P_IGN} phase_t;
  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_oe, reg_we, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  int     n_cmp = 0;
  int     n_bad = 0;
  logic   chk, exp_oe, exp_busy;
  logic [7:0] ptr;
  phase_t phase;
  wr_t    exp_q[$];
  wr_t    log_q[$];
  wr_t    exp_e, got_e;
  logic [7:0] b0, b1;

  always #10ns clk = ~clk;

  // Open-drain bus and a register file whose contents are ~address.
  assign sda_line  = sda_m & ~sda_oe;
  assign reg_rdata = ~reg_addr;

  i2c_target_regs #(.DEV_ADDR(DEV)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_rdata(reg_rdata), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (chk) begin
        check("sda_oe", sda_oe, exp_oe);
        check("busy", busy, exp_busy);
      end
      if (reg_we) begin
        got_e.a = reg_addr;
        got_e.d = reg_wdata;
        log_q.push_back(got_e);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_we: got write 0x%02h @ 0x%02h, expected none", reg_wdata, reg_addr);
        end else begin
          exp_e = exp_q.pop_front();
          check("we_addr", reg_addr, exp_e.a);
          check("we_data", reg_wdata, exp_e.d);
        end
      end
    end
  end

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b;
    #Q; scl_m = 1'b1; chk = 1'b1;
    #Q; s = sda_line;
    #Q; chk = 1'b0; scl_m = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    exp_busy = 1'b0;
    sda_m = 1'b1;
    #Q; scl_m = 1'b1;
    #Q; sda_m = 1'b0;
    #Q; scl_m = 1'b0;
    #Q;
    phase = P_ADDR;
    $display("start");
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    #Q; scl_m = 1'b1;
    #Q; sda_m = 1'b1;
    #Q;
    exp_busy = 1'b0;
    phase = P_IGN;
    $display("stop  reg_addr=0x%02h", reg_addr);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ack, addr_hit, s;
    wr_t w;
    ack = 1'b0;
    addr_hit = 1'b0;
    case (phase)
      P_ADDR: begin
        ack = (b[7:1] == DEV);
        addr_hit = ack;
        phase = !ack ? P_IGN : (b[0] ? P_READ : P_PTR);
      end
      P_PTR: begin
        ack = 1'b1;
        ptr = b;
        phase = P_DATA;
      end
      P_DATA: begin
        ack = 1'b1;
        w.a = ptr;
        w.d = b;
        exp_q.push_back(w);
        ptr = ptr + 8'd1;
      end
      default: ack = 1'b0;
    endcase
    exp_oe = 1'b0;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    if (addr_hit) exp_busy = 1'b1;
    exp_oe = ack;
    clock_bit(1'b1, s);
    exp_oe = 1'b0;
    check("ack_line", s, !ack);
    $display("wr byte 0x%02h ack=%0d", b, !s);
  endtask

  task automatic rd_byte(input logic ack_it, output logic [7:0] got);
    logic [7:0] e;
    logic s;
    e = ~ptr;
    ptr = ptr + 8'd1;
    for (int i = 7; i >= 0; i--) begin
      exp_oe = !e[i];
      clock_bit(1'b1, s);
      got[i] = s;
    end
    exp_oe = 1'b0;
    clock_bit(ack_it ? 1'b0 : 1'b1, s);
    check("rd_byte", got, e);
    if (!ack_it) phase = P_IGN;
    $display("rd byte 0x%02h %s", got, ack_it ? "ack" : "nack");
  endtask

  task automatic check_log2(input logic [7:0] a0, input logic [7:0] d0,
                            input logic [7:0] a1, input logic [7:0] d1);
    check("log_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("log0_addr", log_q[0].a, a0);
      check("log0_data", log_q[0].d, d0);
      check("log1_addr", log_q[1].a, a1);
      check("log1_data", log_q[1].d, d1);
    end
    check("exp_q_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic s;
    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; chk = 1'b0;
    exp_oe = 1'b0; exp_busy = 1'b0; ptr = 8'h00; phase = P_IGN;
    #103;
    check("rst_sda_oe", sda_oe, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    #Q;

    // Pointer write then two data bytes.
    log_q.delete();
    i2c_start(); send_byte(8'hA0); send_byte(8'h10); send_byte(8'h5A); send_byte(8'hC3); i2c_stop();
    check_log2(8'h10, 8'h5A, 8'h11, 8'hC3);
    check("wr_ptr_model", reg_addr, ptr);
    check("wr_ptr_lit", reg_addr, 8'h12);
    check("wr_busy_after_stop", busy, 0);

    // Read with no pointer write continues from the retained pointer.
    i2c_start(); send_byte(8'hA1); rd_byte(1'b0, b0); i2c_stop();
    check("seq_rd_lit", b0, 8'hED);
    check("seq_ptr_lit", reg_addr, 8'h13);

    // Random read via repeated START.
    i2c_start(); send_byte(8'hA0); send_byte(8'h20);
    i2c_start(); send_byte(8'hA1); rd_byte(1'b1, b0); rd_byte(1'b0, b1);
    check("nack_release", sda_oe, 0);
    i2c_stop();
    check("rr_byte0_lit", b0, 8'hDF);
    check("rr_byte1_lit", b1, 8'hDE);
    check("rr_ptr_lit", reg_addr, 8'h22);
    check("rr_ptr_model", reg_addr, ptr);

    // Foreign address and general call are ignored.
    log_q.delete();
    i2c_start(); send_byte(8'hB0); send_byte(8'h00); i2c_stop();
    i2c_start(); send_byte(8'h00); send_byte(8'h33); i2c_stop();
    check("miss_no_we", log_q.size(), 0);
    check("miss_ptr_lit", reg_addr, 8'h22);

    // Pointer wrap.
    log_q.delete();
    i2c_start(); send_byte(8'hA0); send_byte(8'hFF); send_byte(8'h11); send_byte(8'h22); i2c_stop();
    check_log2(8'hFF, 8'h11, 8'h00, 8'h22);
    check("wrap_ptr_lit", reg_addr, 8'h01);

    // STOP after four bits of a data byte.
    log_q.delete();
    i2c_start(); send_byte(8'hA0); send_byte(8'h30);
    exp_oe = 1'b0;
    for (int i = 7; i >= 4; i--) clock_bit(i[0], s);
    i2c_stop();
    check("abort_no_we", log_q.size(), 0);
    check("abort_ptr_lit", reg_addr, 8'h30);
    check("abort_busy", busy, 0);
    check("abort_sda_oe", sda_oe, 0);

    // Reset while the target drives a 0 data bit (~0x40 = 0xBF, bit6 = 0).
    i2c_start(); send_byte(8'hA0); send_byte(8'h40);
    i2c_start(); send_byte(8'hA1);
    exp_oe = 1'b0;
    clock_bit(1'b1, s);
    sda_m = 1'b1;
    #Q; scl_m = 1'b1; exp_oe = 1'b1; chk = 1'b1;
    #Q; chk = 1'b0;
    check("rd_zero_driven", sda_oe, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_sda_oe", sda_oe, 0);
    check("rst_mid_reg_addr", reg_addr, 0);
    check("rst_mid_busy", busy, 0);
    #39;
    reset = 1'b0;
    ptr = 8'h00; exp_busy = 1'b0; exp_oe = 1'b0; phase = P_IGN; exp_q.delete();
    $display("reset mid-read");
    #Q;

    // Clean read after the reset starts at pointer 0.
    i2c_start(); send_byte(8'hA1); rd_byte(1'b0, b0); i2c_stop();
    check("post_rst_rd_lit", b0, 8'hFF);
    check("post_rst_ptr_lit", reg_addr, 8'h01);

    #Q;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
